ext_irq_ctrl: RTL and testbench

EXT_IRQ_CTRL -- requirements
Module: ext_irq_ctrl

---
 rtl/irq_pkg.sv | 5 +
 rtl/irq_prio_sel.sv | 30 +++
 rtl/ext_irq_ctrl.sv | 84 ++++++++
 tb/tb_ext_irq_ctrl.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/irq_pkg.sv
// irq_pkg: presentation FSM encoding and gap counter width shared by ext_irq_ctrl
package irq_pkg;
   typedef enum logic [1:0] {S_IDLE, S_ASSERT, S_GAP} irq_state_e;
   localparam int GAP_W = 4;
endpackage

// File: rtl/irq_prio_sel.sv
// irq_prio_sel: finds the first set bit of i_vec searching upward from i_start with wrap-around
module irq_prio_sel #(
   parameter  int N  = 8,
   localparam int IW = $clog2(N)
) (
   input  logic [N-1:0]  i_vec,
   input  logic [IW-1:0] i_start,
   output logic          o_valid,
   output logic [IW-1:0] o_id
);
   logic [2*N-1:0] w_dbl;
   logic [N-1:0]   w_rot;
   logic [IW:0]    w_sum;

   // rotate so that bit 0 of w_rot is source i_start
   assign w_dbl = {i_vec, i_vec} >> i_start;
   assign w_rot = w_dbl[N-1:0];

   always_comb begin
      o_valid = 1'b0;
      w_sum   = '0;
      for (int k = N-1; k >= 0; k--)
         if (w_rot[k]) begin
            o_valid = 1'b1;
            w_sum   = {1'b0, i_start} + (IW+1)'(k);
         end
   end

   assign o_id = (w_sum >= (IW+1)'(N)) ? IW'(w_sum - (IW+1)'(N)) : w_sum[IW-1:0];
endmodule

// File: rtl/ext_irq_ctrl.sv
// ext_irq_ctrl: collects edge/level interrupt sources and presents one at a time to the core,
// holding it until acknowledged and then enforcing a quiet gap before the next one.
module ext_irq_ctrl
   import irq_pkg::*;
#(
   parameter  int                 NUM_SRC   = 8,
   parameter  logic [NUM_SRC-1:0] EDGE_MASK = '1,
   parameter  int                 RR_MODE   = 0,
   parameter  int                 GAP_CYC   = 2,
   localparam int                 IW        = $clog2(NUM_SRC)
) (
   input  logic               clk_i,
   input  logic               reset_i,
   input  logic [NUM_SRC-1:0] src_i,
   input  logic               en_we_i,
   input  logic [NUM_SRC-1:0] en_wdata_i,
   input  logic               irq_ack_i,
   output logic               meip_o,
   output logic [IW-1:0]      irq_id_o,
   output logic [NUM_SRC-1:0] en_o
);
   irq_state_e         r_state, w_state_nxt;
   logic [NUM_SRC-1:0] r_prev, r_pend, r_en;
   logic [NUM_SRC-1:0] w_set, w_clr, w_elig;
   logic [IW-1:0]      r_id, r_ptr, w_start, w_win;
   logic [GAP_W-1:0]   r_cnt, w_cnt_nxt;
   logic               w_valid, w_ack, w_take;

   // r_pend only ever holds edge bits; level sources are pending while their registered input is high
   assign w_set   = src_i & ~r_prev & EDGE_MASK;
   assign w_elig  = ((r_pend & EDGE_MASK) | (r_prev & ~EDGE_MASK)) & r_en;
   assign w_ack   = (r_state == S_ASSERT) && irq_ack_i;
   assign w_clr   = w_ack ? (NUM_SRC'(1) << r_id) : '0;
   assign w_take  = (r_state == S_IDLE) && w_valid;
   assign w_start = (RR_MODE == 0) ? '0 : (r_ptr == IW'(NUM_SRC-1)) ? '0 : r_ptr + IW'(1);

   irq_prio_sel #(.N(NUM_SRC)) u_sel (
      .i_vec   (w_elig),
      .i_start (w_start),
      .o_valid (w_valid),
      .o_id    (w_win)
   );

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      if (w_take)
         w_state_nxt = S_ASSERT;
      if (w_ack) begin
         w_state_nxt = S_GAP;
         w_cnt_nxt   = GAP_W'(GAP_CYC);
      end
      if (r_state == S_GAP) begin
         w_state_nxt = (r_cnt == GAP_W'(1)) ? S_IDLE : S_GAP;
         w_cnt_nxt   = r_cnt - GAP_W'(1);
      end
   end

   always_ff @(posedge clk_i or negedge reset_i)
      if (!reset_i) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_prev  <= '0;
         r_pend  <= '0;
         r_en    <= '1;
         r_id    <= '0;
         r_ptr   <= IW'(NUM_SRC-1);
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_prev  <= src_i;
         r_pend  <= (r_pend & ~w_clr) | w_set;
         if (en_we_i)
            r_en <= en_wdata_i;
         if (w_take)
            r_id <= w_win;
         if (w_ack)
            r_ptr <= r_id;
      end

   assign meip_o   = (r_state == S_ASSERT);
   assign irq_id_o = r_id;
   assign en_o     = r_en;
endmodule

// File: tb/tb_ext_irq_ctrl.sv
// tb_ext_irq_ctrl: two controller configurations (fixed/all-edge and round-robin/mixed) against a behavioural model
module tb_ext_irq_ctrl;
   localparam int N = 8;
   localparam bit [7:0] P_MASK [2] = '{8'hFF, 8'hB5};
   localparam int       P_RR   [2] = '{0, 1};
   localparam int       P_GAP  [2] = '{2, 3};

   logic       clk, rst_n, en_we, ack_a, ack_b, meip_a, meip_b;
   logic [7:0] src, en_wdata, en_a, en_b;
   logic [2:0] id_a, id_b;
   int         total, bad;

   bit [7:0] m_pe [2], m_prev [2], m_en [2];
   bit       m_as [2];
   int       m_id [2], m_gl [2], m_ptr [2];

   ext_irq_ctrl #(.NUM_SRC(8)) dut_a (
      .clk_i(clk), .reset_i(rst_n), .src_i(src), .en_we_i(en_we), .en_wdata_i(en_wdata),
      .irq_ack_i(ack_a), .meip_o(meip_a), .irq_id_o(id_a), .en_o(en_a));

   ext_irq_ctrl #(.NUM_SRC(8), .EDGE_MASK(8'hB5), .RR_MODE(1), .GAP_CYC(3)) dut_b (
      .clk_i(clk), .reset_i(rst_n), .src_i(src), .en_we_i(en_we), .en_wdata_i(en_wdata),
      .irq_ack_i(ack_b), .meip_o(meip_b), .irq_id_o(id_b), .en_o(en_b));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic m_reset(input int u);
      m_pe[u] = '0; m_prev[u] = '0; m_en[u] = 8'hFF; m_as[u] = 1'b0;
      m_id[u] = 0; m_gl[u] = 0; m_ptr[u] = N - 1;
   endtask

   // one clock of the controller as described by its rules: present, acknowledge, rest, pick
   task automatic m_step(input int u, input bit ack);
      bit [7:0] elig;
      int s, w;
      elig = (m_pe[u] | (m_prev[u] & ~P_MASK[u])) & m_en[u];
      if (m_as[u]) begin
         if (ack) begin
            m_pe[u][m_id[u]] = 1'b0;
            m_ptr[u] = m_id[u];
            m_as[u] = 1'b0;
            m_gl[u] = P_GAP[u];
         end
      end else if (m_gl[u] > 0) begin
         m_gl[u]--;
      end else if (elig != 0) begin
         s = (P_RR[u] != 0) ? (m_ptr[u] + 1) % N : 0;
         w = -1;
         for (int k = 0; k < N; k++)
            if (w < 0 && elig[(s + k) % N]) w = (s + k) % N;
         m_as[u] = 1'b1;
         m_id[u] = w;
      end
      m_pe[u] = m_pe[u] | (src & ~m_prev[u] & P_MASK[u]);
      if (en_we) m_en[u] = en_wdata;
      m_prev[u] = src;
   endtask

   initial begin
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            m_reset(0);
            m_reset(1);
         end
         chk("meip_a", 32'(meip_a), 32'(m_as[0]));
         chk("id_a",   32'(id_a),   m_id[0]);
         chk("en_a",   32'(en_a),   32'(m_en[0]));
         chk("meip_b", 32'(meip_b), 32'(m_as[1]));
         chk("id_b",   32'(id_b),   m_id[1]);
         chk("en_b",   32'(en_b),   32'(m_en[1]));
         if (rst_n) begin
            m_step(0, ack_a);
            m_step(1, ack_b);
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   task automatic tick(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tick(2);
      rst_n = 1'b1;
      tick(1);
   endtask

   int exp33 [4] = '{1, 3, 6, 1};
   int t;

   initial begin
      total = 0; bad = 0;
      rst_n = 1'b0; src = '0; en_we = 1'b0; en_wdata = '0; ack_a = 1'b0; ack_b = 1'b0;
      tick(2);
      rst_n = 1'b1;
      tick(1);
      chk("rst_meip", 32'(meip_a), 0);
      chk("rst_id",   32'(id_a),   0);
      chk("rst_en",   32'(en_a),   32'h0FF);

      // two simultaneous edges: lower index first, the other after the gap
      do_reset();
      src = 8'h24; tick; src = '0; tick;
      chk("r32_first_meip", 32'(meip_a), 1);
      chk("r32_first_id",   32'(id_a),   2);
      ack_a = 1'b1; tick; ack_a = 1'b0;
      chk("r32_gap0", 32'(meip_a), 0);
      tick(2);
      chk("r32_gap1", 32'(meip_a), 0);
      tick;
      chk("r32_second_meip", 32'(meip_a), 1);
      chk("r32_second_id",   32'(id_a),   5);
      ack_a = 1'b1; tick; ack_a = 1'b0;
      tick(8);
      chk("r32_quiet", 32'(meip_a), 0);

      // round-robin over held level sources
      do_reset();
      src = 8'h4A;
      for (int k = 0; k < 4; k++) begin
         t = 0;
         while (!meip_b && t < 20) begin tick; t++; end
         chk("r33_seen", 32'(meip_b), 1);
         chk("r33_id",   32'(id_b),   exp33[k]);
         ack_b = 1'b1; tick; ack_b = 1'b0;
      end
      src = '0;

      // disabled edge is remembered and presented once re-enabled
      do_reset();
      en_we = 1'b1; en_wdata = 8'hEF; tick; en_we = 1'b0;
      src = 8'h10; tick; src = '0; tick(4);
      chk("r34_masked", 32'(meip_a), 0);
      chk("r34_en_off", 32'(en_a),   32'h0EF);
      en_we = 1'b1; en_wdata = 8'hFF; tick; en_we = 1'b0;
      chk("r34_en_on", 32'(en_a),   32'h0FF);
      chk("r34_pre",   32'(meip_a), 0);
      tick;
      chk("r34_meip", 32'(meip_a), 1);
      chk("r34_id",   32'(id_a),   4);

      // new edge coinciding with the ack of the same source survives
      do_reset();
      src = 8'h08; tick; src = '0; tick;
      chk("r35_first", 32'(id_a), 3);
      ack_a = 1'b1; src = 8'h08; tick; ack_a = 1'b0; src = '0;
      chk("r35_gap", 32'(meip_a), 0);
      tick(3);
      chk("r35_again_meip", 32'(meip_a), 1);
      chk("r35_again_id",   32'(id_a),   3);

      // asynchronous reset while asserting
      do_reset();
      src = 8'h01; tick; src = '0; tick;
      chk("r36_assert", 32'(meip_a), 1);
      rst_n = 1'b0; #1;
      chk("r36_async_meip", 32'(meip_a), 0);
      chk("r36_async_id",   32'(id_a),   0);
      tick(2);
      rst_n = 1'b1;
      tick(6);
      chk("r36_after", 32'(meip_a), 0);

      // random traffic, checked every cycle by the model
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 3) == 0) src = 8'($urandom) & 8'($urandom);
         en_we    = ($urandom_range(0, 15) == 0);
         en_wdata = 8'($urandom) | 8'($urandom);
         ack_a    = ($urandom_range(0, 2) == 0);
         ack_b    = ($urandom_range(0, 2) == 0);
         rst_n    = ($urandom_range(0, 499) != 0);
         tick;
      end
      rst_n = 1'b1; src = '0; en_we = 1'b0; ack_a = 1'b0; ack_b = 1'b0;
      tick(2);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
